// File: rtl/bar_pkg.sv
// Shared types and constants for the bartender pour sequencer.
package bar_pkg;

  localparam int unsigned N_CH  = 6;
  localparam int unsigned AMT_W = 4;
  localparam int unsigned CH_W  = 3;

  typedef logic [AMT_W-1:0] amt_t;
  typedef amt_t [N_CH-1:0]  amts_t;

  // Status encodings seen by the order FSM.
  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_POUR = 2'b01;
  localparam logic [1:0] STAT_STIR = 2'b10;
  localparam logic [1:0] STAT_DONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_POUR,
    S_STIR,
    S_DONE
  } state_e;

  // Channel indices, in pour order.
  localparam logic [CH_W-1:0] CH_WH = 3'd0;
  localparam logic [CH_W-1:0] CH_VO = 3'd1;
  localparam logic [CH_W-1:0] CH_LY = 3'd2;
  localparam logic [CH_W-1:0] CH_LI = 3'd3;
  localparam logic [CH_W-1:0] CH_LE = 3'd4;
  localparam logic [CH_W-1:0] CH_WA = 3'd5;

  localparam amt_t AMT_NONE = 4'hF;

  // Recipe ROM, drinks 1..5; each entry packed as {wa, le, li, ly, vo, wh}.
  localparam amts_t RECIPE_ROM [5] = '{
    {4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd3},
    {4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0},
    {4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2},
    {4'd4, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0},
    {4'd3, 4'd2, 4'd0, 4'd2, 4'd0, 4'd0}
  };

  // The "none" code pours nothing.
  function automatic amt_t norm_amt(input amt_t a);
    return (a == AMT_NONE) ? '0 : a;
  endfunction

  // Preset recipe lookup; codes outside 1..5 return all zero.
  function automatic amts_t recipe(input logic [2:0] d);
    case (d)
      3'd1:    return RECIPE_ROM[0];
      3'd2:    return RECIPE_ROM[1];
      3'd3:    return RECIPE_ROM[2];
      3'd4:    return RECIPE_ROM[3];
      3'd5:    return RECIPE_ROM[4];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/unit_timer.sv
// Pour-unit prescaler: one-cycle unit_tick_c every TICKS_PER_UNIT cycles after restart.
module unit_timer #(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic unit_tick_c
);

  localparam int unsigned CNT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_UNIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign unit_tick_c = (cnt_q == LAST);

  // Next count: restart zeroes so the phase that follows is exactly N units long.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || unit_tick_c) begin
      cnt_d = '0;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pour_sequencer.sv
// Pour sequencer: runs the six ingredient pumps in order, then stirs, then pulses done.
// Optional stir phase is built only when STIR_EN is defined.
module pour_sequencer
  import bar_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000,
  parameter int unsigned STIR_UNITS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] drink,
  input  logic [3:0] c_wh,
  input  logic [3:0] c_vo,
  input  logic [3:0] c_ly,
  input  logic [3:0] c_li,
  input  logic [3:0] c_le,
  input  logic [3:0] c_wa,
  output logic [1:0] status,
  output logic       m_wh,
  output logic       m_vo,
  output logic       m_ly,
  output logic       m_li,
  output logic       m_le,
  output logic       m_wa,
  output logic       st,
  output logic       done
);

  localparam amt_t STIR_LOAD = AMT_W'(STIR_UNITS);
`ifdef STIR_EN
  localparam state_e END_ST = S_STIR;
`else
  localparam state_e END_ST = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  amt_t            units_q, units_d;
  amts_t           amts_q, amts_d;
  logic [1:0]      status_q, status_d;
  logic [N_CH-1:0] pump_q, pump_d;
  logic            done_q, done_d;
`ifdef STIR_EN
  logic            st_q, st_d;
`endif

  logic  unit_tick_c;
  logic  restart_c;
  amts_t cust_amts;

  assign cust_amts = {norm_amt(c_wa), norm_amt(c_le), norm_amt(c_li),
                      norm_amt(c_ly), norm_amt(c_vo), norm_amt(c_wh)};

  unit_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_unit_timer (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart_c),
    .unit_tick_c(unit_tick_c)
  );

  // Next-state, counters, and the output values for the state being entered.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    units_d   = units_q;
    amts_d    = amts_q;
    status_d  = STAT_IDLE;
    pump_d    = '0;
    done_d    = 1'b0;
`ifdef STIR_EN
    st_d      = 1'b0;
`endif
    restart_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          ch_d = CH_WH;
          if (drink >= 3'd1 && drink <= 3'd5) begin
            amts_d  = recipe(drink);
            state_d = S_SELECT;
          end else if (drink == 3'd6) begin
            amts_d  = cust_amts;
            state_d = S_SELECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SELECT: begin
        if (amts_q[ch_q] != '0) begin
          units_d = amts_q[ch_q];
          state_d = S_POUR;
        end else if (ch_q == CH_WA) begin
          units_d = STIR_LOAD;
          state_d = END_ST;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_POUR: begin
        if (unit_tick_c) begin
          if (units_q == AMT_W'(1)) begin
            if (ch_q == CH_WA) begin
              units_d = STIR_LOAD;
              state_d = END_ST;
            end else begin
              ch_d    = ch_q + CH_W'(1);
              state_d = S_SELECT;
            end
          end else begin
            units_d = units_q - AMT_W'(1);
          end
        end
      end
      S_STIR: begin
        if (unit_tick_c) begin
          if (units_q == AMT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            units_d = units_q - AMT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    restart_c = ((state_d == S_POUR) || (state_d == S_STIR)) && (state_d != state_q);

    case (state_d)
      S_SELECT: status_d = STAT_POUR;
      S_POUR: begin
        status_d = STAT_POUR;
        pump_d   = N_CH'(1) << ch_d;
      end
      S_STIR: begin
        status_d = STAT_STIR;
`ifdef STIR_EN
        st_d     = 1'b1;
`endif
      end
      S_DONE: begin
        status_d = STAT_DONE;
        done_d   = 1'b1;
      end
      default: status_d = STAT_IDLE;
    endcase
  end

  // State, order data and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      units_q  <= '0;
      amts_q   <= '0;
      status_q <= STAT_IDLE;
      pump_q   <= '0;
      done_q   <= 1'b0;
`ifdef STIR_EN
      st_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      units_q  <= units_d;
      amts_q   <= amts_d;
      status_q <= status_d;
      pump_q   <= pump_d;
      done_q   <= done_d;
`ifdef STIR_EN
      st_q     <= st_d;
`endif
    end
  end

  assign status = status_q;
  assign m_wh   = pump_q[CH_WH];
  assign m_vo   = pump_q[CH_VO];
  assign m_ly   = pump_q[CH_LY];
  assign m_li   = pump_q[CH_LI];
  assign m_le   = pump_q[CH_LE];
  assign m_wa   = pump_q[CH_WA];
  assign done   = done_q;
`ifdef STIR_EN
  assign st     = st_q;
`else
  assign st     = 1'b0;
`endif

endmodule

// File: tb/tb_pour_sequencer.sv
// Directed bench for pour_sequencer with TICKS_PER_UNIT = 4, STIR_UNITS = 2.
module tb_pour_sequencer;

  localparam int unsigned TPU = 4;
  localparam int unsigned SU  = 2;
`ifdef STIR_EN
  localparam int STIR_CYC = 8;
`else
  localparam int STIR_CYC = 0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] drink;
  logic [3:0] c_wh, c_vo, c_ly, c_li, c_le, c_wa;
  logic [1:0] status;
  logic       m_wh, m_vo, m_ly, m_li, m_le, m_wa, st, done;
  logic [5:0] pumps;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by capture for one order.
  int pump_cnt   [6];
  int pump_first [6];
  int pump_last  [6];
  int multi, st_cnt, s01, s10, s11, done_cnt, done_cyc, done_mis;
  logic [1:0] post_status;
  logic [5:0] post_pumps;

  assign pumps = {m_wa, m_le, m_li, m_ly, m_vo, m_wh};

  pour_sequencer #(
    .TICKS_PER_UNIT(TPU),
    .STIR_UNITS    (SU)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .drink (drink),
    .c_wh  (c_wh),
    .c_vo  (c_vo),
    .c_ly  (c_ly),
    .c_li  (c_li),
    .c_le  (c_le),
    .c_wa  (c_wa),
    .status(status),
    .m_wh  (m_wh),
    .m_vo  (m_vo),
    .m_ly  (m_ly),
    .m_li  (m_li),
    .m_le  (m_le),
    .m_wa  (m_wa),
    .st    (st),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse en for one cycle; returns at the negedge showing cycle 1 after the sampling edge.
  task automatic start_order(input logic [2:0] d);
    @(negedge clk);
    drink = d;
    en    = 1'b1;
    @(negedge clk);
    en    = 1'b0;
  endtask

  // Sample outputs once per cycle until 4 cycles past done (or 200 cycles); optional stray en.
  task automatic capture(input int en_at);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      pump_cnt[i] = 0; pump_first[i] = -1; pump_last[i] = -1;
    end
    multi = 0; st_cnt = 0; s01 = 0; s10 = 0; s11 = 0;
    done_cnt = 0; done_cyc = -1; done_mis = 0;
    post_status = 2'bxx; post_pumps = 6'bxxxxxx;
    while (cyc < 200 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
      cyc++;
      for (int i = 0; i < 6; i++) begin
        if (pumps[i] === 1'b1) begin
          if (pump_cnt[i] == 0) pump_first[i] = cyc;
          pump_last[i] = cyc;
          pump_cnt[i]++;
        end
      end
      if ($countones(pumps) > 1) multi++;
      if (st === 1'b1) st_cnt++;
      if (status === 2'b01) s01++;
      if (status === 2'b10) s10++;
      if (status === 2'b11) s11++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done !== (status === 2'b11)) done_mis++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        post_status = status;
        post_pumps  = pumps;
      end
      if (cyc == en_at) begin
        en = 1'b1; drink = 3'd5;
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (status !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b exp 00", status); end
    n_tests++; if (pumps !== 6'b0) begin n_fail++; $display("FAIL reset_pumps got %b exp 000000", pumps); end
    n_tests++; if (st !== 1'b0) begin n_fail++; $display("FAIL reset_st got %b exp 0", st); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  // Drink 3: wh 2 units (cycles 2..9), wa 4 units (cycles 15..30), stir, done.
  task automatic check_drink3(input string tag);
    n_tests++; if (pump_cnt[0] != 8) begin n_fail++; $display("FAIL %s wh_len got %0d exp 8", tag, pump_cnt[0]); end
    n_tests++; if (pump_first[0] != 2 || pump_last[0] != 9) begin n_fail++; $display("FAIL %s wh_span got %0d..%0d exp 2..9", tag, pump_first[0], pump_last[0]); end
    n_tests++; if (pump_cnt[5] != 16) begin n_fail++; $display("FAIL %s wa_len got %0d exp 16", tag, pump_cnt[5]); end
    n_tests++; if (pump_first[5] != 15 || pump_last[5] != 30) begin n_fail++; $display("FAIL %s wa_span got %0d..%0d exp 15..30", tag, pump_first[5], pump_last[5]); end
    n_tests++; if (pump_cnt[1] + pump_cnt[2] + pump_cnt[3] + pump_cnt[4] != 0) begin n_fail++; $display("FAIL %s other_pumps got %0d exp 0", tag, pump_cnt[1] + pump_cnt[2] + pump_cnt[3] + pump_cnt[4]); end
    n_tests++; if (multi != 0) begin n_fail++; $display("FAIL %s multi_pump got %0d exp 0", tag, multi); end
    n_tests++; if (s01 != 30) begin n_fail++; $display("FAIL %s status01_cycles got %0d exp 30", tag, s01); end
    n_tests++; if (s10 != STIR_CYC) begin n_fail++; $display("FAIL %s status10_cycles got %0d exp %0d", tag, s10, STIR_CYC); end
    n_tests++; if (st_cnt != STIR_CYC) begin n_fail++; $display("FAIL %s st_cycles got %0d exp %0d", tag, st_cnt, STIR_CYC); end
    n_tests++; if (s11 != 1 || done_cnt != 1) begin n_fail++; $display("FAIL %s done_count got %0d/%0d exp 1/1", tag, s11, done_cnt); end
    n_tests++; if (done_cyc != 31 + STIR_CYC) begin n_fail++; $display("FAIL %s done_cycle got %0d exp %0d", tag, done_cyc, 31 + STIR_CYC); end
    n_tests++; if (done_mis != 0) begin n_fail++; $display("FAIL %s done_vs_status got %0d exp 0", tag, done_mis); end
    n_tests++; if (post_status !== 2'b00 || post_pumps !== 6'b0) begin n_fail++; $display("FAIL %s post_idle got %b/%b exp 00/000000", tag, post_status, post_pumps); end
  endtask

  task automatic test_drink3();
    start_order(3'd3);
    capture(-1);
    check_drink3("drink3");
  endtask

  // Custom: vo 2 units (cycles 3..10), li = none code.
  task automatic test_custom();
    c_wh = 4'd0; c_vo = 4'd2; c_ly = 4'd0; c_li = 4'd15; c_le = 4'd0; c_wa = 4'd0;
    start_order(3'd6);
    capture(-1);
    n_tests++; if (pump_cnt[1] != 8) begin n_fail++; $display("FAIL custom vo_len got %0d exp 8", pump_cnt[1]); end
    n_tests++; if (pump_first[1] != 3) begin n_fail++; $display("FAIL custom vo_first got %0d exp 3", pump_first[1]); end
    n_tests++; if (pump_cnt[3] != 0) begin n_fail++; $display("FAIL custom li_len got %0d exp 0", pump_cnt[3]); end
    n_tests++; if (pump_cnt[0] + pump_cnt[2] + pump_cnt[4] + pump_cnt[5] != 0) begin n_fail++; $display("FAIL custom other_pumps got %0d exp 0", pump_cnt[0] + pump_cnt[2] + pump_cnt[4] + pump_cnt[5]); end
    n_tests++; if (s01 != 14) begin n_fail++; $display("FAIL custom pour_phase got %0d exp 14", s01); end
    n_tests++; if (done_cyc != 15 + STIR_CYC) begin n_fail++; $display("FAIL custom done_cycle got %0d exp %0d", done_cyc, 15 + STIR_CYC); end
    c_vo = 4'd0; c_li = 4'd0;
  endtask

  task automatic test_invalid();
    start_order(3'd0);
    capture(-1);
    n_tests++; if (done_cyc != 1) begin n_fail++; $display("FAIL invalid0 done_cycle got %0d exp 1", done_cyc); end
    n_tests++; if (pump_cnt[0] + pump_cnt[1] + pump_cnt[2] + pump_cnt[3] + pump_cnt[4] + pump_cnt[5] + st_cnt != 0) begin n_fail++; $display("FAIL invalid0 motors got %0d exp 0", pump_cnt[0] + pump_cnt[1] + pump_cnt[2] + pump_cnt[3] + pump_cnt[4] + pump_cnt[5] + st_cnt); end
    n_tests++; if (s01 + s10 != 0) begin n_fail++; $display("FAIL invalid0 busy_status got %0d exp 0", s01 + s10); end
    n_tests++; if (post_status !== 2'b00) begin n_fail++; $display("FAIL invalid0 post_status got %b exp 00", post_status); end
    start_order(3'd7);
    capture(-1);
    n_tests++; if (done_cyc != 1 || done_cnt != 1) begin n_fail++; $display("FAIL invalid7 done got cyc %0d cnt %0d exp 1/1", done_cyc, done_cnt); end
  endtask

  task automatic test_en_ignored();
    start_order(3'd3);
    capture(4);
    check_drink3("en_ignored");
  endtask

  // Reset during the 4th cycle of m_wa (cycle 18), then a fresh drink-2 order.
  task automatic test_reset_mid_pour();
    start_order(3'd3);
    repeat (17) @(negedge clk);
    n_tests++; if (m_wa !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre_wa got %b exp 1", m_wa); end
    rst = 1'b1;
    #1;
    n_tests++; if (pumps !== 6'b0 || st !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid motors got %b/%b/%b exp 000000/0/0", pumps, st, done); end
    n_tests++; if (status !== 2'b00) begin n_fail++; $display("FAIL rst_mid status got %b exp 00", status); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (status !== 2'b00 || pumps !== 6'b0) begin n_fail++; $display("FAIL rst_mid idle got %b/%b exp 00/000000", status, pumps); end
    start_order(3'd2);
    capture(-1);
    n_tests++; if (pump_cnt[1] != 8 || pump_cnt[2] != 4 || pump_cnt[3] != 4) begin n_fail++; $display("FAIL rst_mid fresh_pumps got %0d/%0d/%0d exp 8/4/4", pump_cnt[1], pump_cnt[2], pump_cnt[3]); end
    n_tests++; if (pump_first[1] != 3 || pump_first[2] != 12 || pump_first[3] != 17) begin n_fail++; $display("FAIL rst_mid fresh_order got %0d/%0d/%0d exp 3/12/17", pump_first[1], pump_first[2], pump_first[3]); end
    n_tests++; if (done_cyc != 23 + STIR_CYC) begin n_fail++; $display("FAIL rst_mid fresh_done got %0d exp %0d", done_cyc, 23 + STIR_CYC); end
  endtask

  // Drink 1: wh 3, li 1, le 1; pour phase ends at cycle 26.
  task automatic test_drink1();
    start_order(3'd1);
    capture(-1);
    n_tests++; if (pump_cnt[0] != 12 || pump_cnt[3] != 4 || pump_cnt[4] != 4) begin n_fail++; $display("FAIL drink1 pumps got %0d/%0d/%0d exp 12/4/4", pump_cnt[0], pump_cnt[3], pump_cnt[4]); end
    n_tests++; if (pump_first[3] != 17 || pump_first[4] != 22) begin n_fail++; $display("FAIL drink1 order got %0d/%0d exp 17/22", pump_first[3], pump_first[4]); end
    n_tests++; if (s01 != 26) begin n_fail++; $display("FAIL drink1 pour_phase got %0d exp 26", s01); end
    n_tests++; if (st_cnt != STIR_CYC) begin n_fail++; $display("FAIL drink1 st_cycles got %0d exp %0d", st_cnt, STIR_CYC); end
    n_tests++; if (done_cyc != 27 + STIR_CYC) begin n_fail++; $display("FAIL drink1 done_cycle got %0d exp %0d", done_cyc, 27 + STIR_CYC); end
    n_tests++; if (multi != 0) begin n_fail++; $display("FAIL drink1 multi_pump got %0d exp 0", multi); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; drink = 3'd0;
    c_wh = 4'd0; c_vo = 4'd0; c_ly = 4'd0; c_li = 4'd0; c_le = 4'd0; c_wa = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_drink3();
    test_custom();
    test_invalid();
    test_en_ignored();
    test_reset_mid_pour();
    test_drink1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pour_sequencer.md
# pour_sequencer

Responder end of the bartender interface. Accepts one drink order from the order FSM (`en` plus drink code and six custom amounts) and reports progress on `status`. Drives the six ingredient pump enables one at a time, then the stirrer, and pulses `done` when the drink is finished. The order FSM asserts `en` only while `status` = 00, and returns to its order state on the `done` pulse.

## Interface
Parameters:
- TICKS_PER_UNIT, 50_000_000: clk cycles per pour unit (1 s at 50 MHz).
- STIR_UNITS, 3: stir duration, in units.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  order request; sampled only in IDLE
- drink  in  3  1–5 preset recipe, 6 custom, 0/7 invalid
- c_wh, c_vo, c_ly, c_li, c_le, c_wa  in  4 each  custom amounts in units; used only when drink = 6
- status  out  2  00 idle, 01 pouring, 10 stirring, 11 done
- m_wh, m_vo, m_ly, m_li, m_le, m_wa  out  1 each  pump enables
- st  out  1  stirrer enable
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE → SELECT → POUR → (SELECT …) → STIR → DONE → IDLE.
- IDLE:
  - All outputs 0.
  - On `en` = 1, latch six 4-bit amounts: the recipe ROM entry for drinks 1–5, or the `c_*` inputs for drink 6.
  - Clear channel index to 0 and go to SELECT.
- Invalid drink (0/7) with `en` = 1: go straight to DONE. No pumps run and no stir occurs.
- Amount 15 is the "none" code and is treated as 0. Valid amounts are 0–14.
- SELECT:
  - Lasts one cycle. All pumps off; status = 01.
  - If the latched amount for the current channel is non-zero, load the unit counter and tick counter and go to POUR.
  - Otherwise advance the channel.
  - Leaving channel 5 goes to STIR.
- POUR:
  - Only the pump for the current channel is on; status = 01.
  - Runs exactly amount × TICKS_PER_UNIT cycles, then returns to SELECT with the next channel.
- Channel order: wh, vo, ly, li, le, wa. At most one pump is high in any cycle.
- STIR: `st` = 1 and status = 10 for STIR_UNITS × TICKS_PER_UNIT cycles, then go to DONE.
- DONE: status = 11 and `done` = 1 for exactly one cycle, then go to IDLE.
- `en` is ignored in every state except IDLE. Input changes after the latch have no effect.
- Recipe ROM (wh, vo, ly, li, le, wa):
  - drink 1: 3, 0, 0, 1, 1, 0
  - drink 2: 0, 2, 1, 1, 0, 0
  - drink 3: 2, 0, 0, 0, 0, 4
  - drink 4: 0, 2, 0, 0, 0, 4
  - drink 5: 0, 0, 2, 0, 2, 3

## Timing
- Reset values: status = 00, every pump = 0, `st` = 0, `done` = 0, state IDLE.
- Reset asserted mid-pour or mid-stir forces all motors off immediately (asynchronous). The order is discarded.
- The first SELECT cycle is the cycle after the edge that samples `en`.
- Pour phase length is 6 + Σamount × TICKS_PER_UNIT cycles (one SELECT per channel).
- Total latency from the `en` edge to `done` = pour phase + STIR_UNITS × TICKS_PER_UNIT + 1.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Counters:
  - Tick counter is sized for TICKS_PER_UNIT − 1.
  - Unit counter is 4 bits and counts down to 1.
  - No wrap occurs for amount ≤ 14.

## Configuration
- STIR_EN defined: the STIR state exists as described.
- STIR_EN not defined:
  - STIR is removed and SELECT after channel 5 goes directly to DONE.
  - `st` is tied to 0.
  - status never takes the value 10.

## Structure
- Package `bar_pkg`:
  - status encodings
  - state enum
  - channel index constants
  - 5×6 recipe ROM constant
  - the "none" code (4'hF)
- Sub-module `unit_timer`:
  - Prescaler producing a one-cycle `unit_tick` every TICKS_PER_UNIT cycles.
  - Restart input, cleared on each POUR/STIR entry, so every phase length is exact.

## Test plan
Test parameters: TICKS_PER_UNIT = 4, STIR_UNITS = 2.
- Drink 3, pulse `en` → `m_wh` high for exactly 8 cycles, then `m_wa` for exactly 16. The two pumps are never simultaneous. status = 01 for 30 cycles, 10 for 8, then 11 for 1 with `done` = 1, then 00.
- Drink 6 with c_vo = 2, c_li = 15, all others 0 → only `m_vo` pulses (8 cycles). Pour phase = 14 cycles. `m_li` never asserts.
- Drink 0 with `en` → the next cycle is DONE (status 11, `done` = 1). No motor ever asserts; status returns to 00.
- Pulse `en` again during POUR with drink 5 → ignored. The drink-3 sequence completes unchanged and exactly one `done` pulse occurs.
- Assert `rst` during the 4th cycle of `m_wa` → all outputs are 0 in the same cycle and status = 00. A new `en` after reset starts a fresh sequence.
- STIR_EN undefined, drink 1 → after channel 5 SELECT, DONE follows immediately. `st` stays 0 throughout.
